// File: rtl/csr_counter_bank_if.sv
// CSR read/write bus for csr_counter_bank: one write port and one
// registered read port, each addressing a counter and a 32-bit half.
interface csr_counter_bank_if #(
  parameter int XLEN  = 32,
  parameter int SEL_W = 2
) ();
  logic             wr_en_i;
  logic [SEL_W-1:0] wr_sel_i;
  logic             wr_hi_i;
  logic [XLEN-1:0]  wr_data_i;
  logic             rd_en_i;
  logic [SEL_W-1:0] rd_sel_i;
  logic             rd_hi_i;
  logic [XLEN-1:0]  rd_data_o;
  logic             rd_valid_o;

  modport master (
    output wr_en_i, wr_sel_i, wr_hi_i, wr_data_i, rd_en_i, rd_sel_i, rd_hi_i,
    input  rd_data_o, rd_valid_o
  );
  modport slave (
    input  wr_en_i, wr_sel_i, wr_hi_i, wr_data_i, rd_en_i, rd_sel_i, rd_hi_i,
    output rd_data_o, rd_valid_o
  );
endinterface

// File: rtl/csr_counter_bank.sv
// Bank of NUM_CNT 2*XLEN-bit event counters with a CSR read/write port.
// Define CSR_CNT_OVF_EN to build sticky overflow flags and irq_o.
module csr_cnt_lane #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              inhibit,
  input  logic              wr_lo,
  input  logic              wr_hi,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              ovf_clr,
  output logic [2*XLEN-1:0] cnt,
  output logic              ovf
);
  logic bump;

  // A write to either half blocks the increment on that edge.
  assign bump = inc & ~inhibit & ~(wr_lo | wr_hi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (wr_lo) cnt[XLEN-1:0] <= wr_data;
    else if (wr_hi) cnt[2*XLEN-1:XLEN] <= wr_data;
    else if (bump)  cnt <= cnt + (2*XLEN)'(1);
  end

`ifdef CSR_CNT_OVF_EN
  // Wrap beats a same-edge clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               ovf <= 1'b0;
    else if (bump && &cnt) ovf <= 1'b1;
    else if (ovf_clr)      ovf <= 1'b0;
  end
`else
  logic unused_clr;
  assign unused_clr = ovf_clr;
  assign ovf        = 1'b0;
`endif
endmodule

module csr_counter_bank #(
  parameter int NUM_CNT = 4,
  parameter int XLEN    = 32,
  parameter int SEL_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CNT-1:0] inc_i,
  input  logic [NUM_CNT-1:0] inhibit_i,
  input  logic [NUM_CNT-1:0] ovf_clr_i,
  csr_counter_bank_if.slave  bus,
  output logic [NUM_CNT-1:0] ovf_o,
  output logic               irq_o
);
  localparam int STAGES = 0;

  if (SEL_W < 1 || SEL_W < $clog2(NUM_CNT)) begin : g_bad_sel_w
    $error("csr_counter_bank: SEL_W too narrow for NUM_CNT");
  end

  logic [NUM_CNT-1:0][2*XLEN-1:0] cnt;
  logic [XLEN-1:0]                rd_mux;
  logic [STAGES:0]                vld_pipe;

  for (genvar n = 0; n < NUM_CNT; n++) begin : g_lane
    logic sel_wr;
    assign sel_wr = bus.wr_en_i && (bus.wr_sel_i == SEL_W'(n));

    csr_cnt_lane #(.XLEN(XLEN)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc_i[n]),
      .inhibit (inhibit_i[n]),
      .wr_lo   (sel_wr & ~bus.wr_hi_i),
      .wr_hi   (sel_wr &  bus.wr_hi_i),
      .wr_data (bus.wr_data_i),
      .ovf_clr (ovf_clr_i[n]),
      .cnt     (cnt[n]),
      .ovf     (ovf_o[n])
    );
  end

  assign irq_o = |ovf_o;

  // Out-of-range selects match no lane and fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int n = 0; n < NUM_CNT; n++)
      if (bus.rd_sel_i == SEL_W'(n))
        rd_mux = bus.rd_hi_i ? cnt[n][2*XLEN-1:XLEN] : cnt[n][XLEN-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_data_o <= '0;
      vld_pipe      <= '0;
    end else begin
      if (bus.rd_en_i) bus.rd_data_o <= rd_mux;
      vld_pipe[0] <= bus.rd_en_i;
      for (int s = 1; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  assign bus.rd_valid_o = vld_pipe[STAGES];
endmodule
